// File: rtl/apb_ucpd_debounce.sv
// ---------------------------------------------------------------------------
// apb_ucpd_debounce
// Multi-channel input debouncer with a shared microsecond prescaler and
// sample divider. A channel accepts a new level once det_cnt consecutive
// samples (minimum 1) disagree with its current debounced output.
// A single matching sample clears the partial count.
//
// Optional feature macro: UCPD_DEBOUNCE_SYNC_EN
//   defined   -> each din bit passes a 2-flop synchronizer (+2 cycles latency)
//   undefined -> din is sampled directly
// ---------------------------------------------------------------------------
module apb_ucpd_debounce #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
) (
    input  logic             ic_clk,
    input  logic             ic_rst,
    input  logic [5:0]       clk_freq,
    input  logic [9:0]       det_us,
    input  logic [CNT_W-1:0] det_cnt,
    input  logic [NCH-1:0]   ch_en,
    input  logic [NCH-1:0]   din,
    output logic [NCH-1:0]   dout,
    output logic [NCH-1:0]   rise,
    output logic [NCH-1:0]   fall,
    output logic [NCH-1:0]   busy
);

    // Shared timebase
    logic [5:0]       presc_r;
    logic [9:0]       div_r;
    logic [5:0]       presc_term_s;
    logic [9:0]       div_term_s;
    logic             us_tick_s;
    logic             sample_tick_s;

    // Per-channel state
    logic [NCH-1:0]   x_s;
    logic [CNT_W-1:0] eff_s;
    logic [CNT_W-1:0] cnt_r     [NCH];
    logic [CNT_W-1:0] cnt_nxt_s [NCH];
    logic [NCH-1:0]   dout_r;
    logic [NCH-1:0]   rise_r;
    logic [NCH-1:0]   fall_r;
    logic [NCH-1:0]   busy_r;
    logic [NCH-1:0]   dout_nxt_s;
    logic [NCH-1:0]   rise_nxt_s;
    logic [NCH-1:0]   fall_nxt_s;
    logic [NCH-1:0]   busy_nxt_s;

`ifdef UCPD_DEBOUNCE_SYNC_EN
    logic [NCH-1:0]   sync1_r;
    logic [NCH-1:0]   sync2_r;

    // Two-flop synchronizer on the raw channel inputs
    always_ff @(posedge ic_clk) begin
        if (ic_rst) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
        end
    end

    assign x_s = sync2_r;
`else
    assign x_s = din;
`endif

    // Terminal counts; a zero setting behaves like one (tick every step).
    // Equality compare lets a count above a lowered terminal run on and wrap.
    always_comb begin
        presc_term_s  = 6'd0;
        div_term_s    = 10'd0;
        if (clk_freq == 6'd0) begin
            presc_term_s = 6'd0;
        end else begin
            presc_term_s = clk_freq - 6'd1;
        end
        if (det_us == 10'd0) begin
            div_term_s = 10'd0;
        end else begin
            div_term_s = det_us - 10'd1;
        end
        us_tick_s     = (presc_r == presc_term_s);
        sample_tick_s = us_tick_s && (div_r == div_term_s);
    end

    // Free-running us prescaler and sample divider shared by all channels
    always_ff @(posedge ic_clk) begin
        if (ic_rst) begin
            presc_r <= 6'd0;
            div_r   <= 10'd0;
        end else begin
            if (us_tick_s) begin
                presc_r <= 6'd0;
                if (sample_tick_s) begin
                    div_r <= 10'd0;
                end else begin
                    div_r <= div_r + 10'd1;
                end
            end else begin
                presc_r <= presc_r + 6'd1;
                div_r   <= div_r;
            end
        end
    end

    // Effective required sample count: det_cnt of zero acts as one
    always_comb begin
        eff_s = det_cnt;
        if (det_cnt == {CNT_W{1'b0}}) begin
            eff_s = CNT_W'(1);
        end else begin
            eff_s = det_cnt;
        end
    end

    // Per-channel accept / count / reject decision
    always_comb begin
        logic [CNT_W:0] run_v;
        run_v      = '0;
        dout_nxt_s = dout_r;
        rise_nxt_s = '0;
        fall_nxt_s = '0;
        busy_nxt_s = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
            run_v        = {1'b0, cnt_r[i]} + {{CNT_W{1'b0}}, 1'b1};
            if (!ch_en[i]) begin
                cnt_nxt_s[i] = '0;
            end else if (sample_tick_s) begin
                if (x_s[i] != dout_r[i]) begin
                    if (run_v >= {1'b0, eff_s}) begin
                        dout_nxt_s[i] = x_s[i];
                        rise_nxt_s[i] = x_s[i];
                        fall_nxt_s[i] = ~x_s[i];
                        cnt_nxt_s[i]  = '0;
                    end else begin
                        cnt_nxt_s[i] = run_v[CNT_W-1:0];
                    end
                end else begin
                    cnt_nxt_s[i] = '0;
                end
            end else begin
                cnt_nxt_s[i] = cnt_r[i];
            end
            busy_nxt_s[i] = (cnt_nxt_s[i] != {CNT_W{1'b0}});
        end
    end

    // Channel state and registered outputs
    always_ff @(posedge ic_clk) begin
        if (ic_rst) begin
            dout_r <= '0;
            rise_r <= '0;
            fall_r <= '0;
            busy_r <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            dout_r <= dout_nxt_s;
            rise_r <= rise_nxt_s;
            fall_r <= fall_nxt_s;
            busy_r <= busy_nxt_s;
            for (int i = 0; i < NCH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    assign dout = dout_r;
    assign rise = rise_r;
    assign fall = fall_r;
    assign busy = busy_r;

endmodule
